// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single-port data memory between the CPU load/store path and a
//   host/debug port. Per-cycle round-robin arbitration, with a host lock that
//   lets the host keep the memory for up to MAX_LOCK consecutive grants before
//   the CPU is forced one grant. Read data is registered per requester.
//
// Ports:
//   clk, rst                 system clock, async active-high reset
//   cpu_req/we/be/opr/addr/wdata   CPU access request and payload
//   cpu_gnt, cpu_stall       CPU access performed this cycle / CPU waiting
//   cpu_rvalid, cpu_rdata    CPU read return (one cycle after granted read)
//   host_req/lock/we/be/addr/wdata host access request and payload
//   host_gnt                 host access performed this cycle
//   host_rvalid, host_rdata  host read return (one cycle after granted read)
//   mem_we/be/opr/addr/wdata to data memory
//   mem_rdata                combinational read data from data memory
module dmem_arbiter #(
  parameter int AW       = 15,
  parameter int DW       = 32,
  parameter int MAX_LOCK = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [3:0]    cpu_be,
  input  logic [2:0]    cpu_opr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_stall,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          host_req,
  input  logic          host_lock,
  input  logic          host_we,
  input  logic [3:0]    host_be,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [2:0]    mem_opr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] LOCK_MAX = CW'(MAX_LOCK);

  // State records the owner of the previous cycle.
  localparam logic [1:0] S_IDLE        = 2'd0;
  localparam logic [1:0] S_CPU         = 2'd1;
  localparam logic [1:0] S_HOST        = 2'd2;
  localparam logic [1:0] S_HOST_LOCKED = 2'd3;

  localparam logic LG_CPU  = 1'b0;
  localparam logic LG_HOST = 1'b1;

  localparam logic [2:0] OPR_WORD = 3'b010;

  logic [1:0]    state;
  logic          last_grant;
  logic [CW-1:0] lock_cnt;
  logic          lock_hold;

  // The locked host keeps the memory only while it still asks for the lock
  // and the budget is not exhausted; otherwise plain round-robin applies,
  // which hands the CPU its forced grant at timeout (last_grant is HOST).
  assign lock_hold = (state == S_HOST_LOCKED) && host_req && host_lock &&
                     (lock_cnt < LOCK_MAX);

  always_comb begin
    cpu_gnt  = 1'b0;
    host_gnt = 1'b0;
    if (lock_hold) begin
      host_gnt = 1'b1;
    end else if (cpu_req && host_req) begin
      if (last_grant == LG_HOST) cpu_gnt  = 1'b1;
      else                       host_gnt = 1'b1;
    end else if (cpu_req) begin
      cpu_gnt = 1'b1;
    end else if (host_req) begin
      host_gnt = 1'b1;
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;

  // Memory-side mux: CPU values are the idle default.
  always_comb begin
    mem_be    = cpu_be;
    mem_opr   = cpu_opr;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = cpu_we & cpu_gnt;
    if (host_gnt) begin
      mem_be    = host_be;
      mem_opr   = OPR_WORD;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
      mem_we    = host_we;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      last_grant <= LG_HOST;
      lock_cnt   <= '0;
    end else if (cpu_gnt) begin
      state      <= S_CPU;
      last_grant <= LG_CPU;
      lock_cnt   <= '0;
    end else if (host_gnt) begin
      last_grant <= LG_HOST;
      if (host_lock) begin
        state <= S_HOST_LOCKED;
        if (lock_cnt != LOCK_MAX) lock_cnt <= lock_cnt + 1'b1;
      end else begin
        state    <= S_HOST;
        lock_cnt <= '0;
      end
    end else begin
      state <= S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_rvalid  <= 1'b0;
      cpu_rdata   <= '0;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
    end else begin
      cpu_rvalid  <= cpu_gnt & ~cpu_we;
      host_rvalid <= host_gnt & ~host_we;
      if (cpu_gnt && !cpu_we)   cpu_rdata  <= mem_rdata;
      if (host_gnt && !host_we) host_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter with a small word-addressed memory model
//   attached to the mem_* port.
module tb_dmem_arbiter;

  localparam int AW = 15;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we;
  logic [3:0]    cpu_be;
  logic [2:0]    cpu_opr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt, cpu_stall, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          host_req, host_lock, host_we;
  logic [3:0]    host_be;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt, host_rvalid;
  logic [DW-1:0] host_rdata;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [2:0]    mem_opr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(16)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_opr(cpu_opr),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_lock(host_lock), .host_we(host_we),
    .host_be(host_be), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_we(mem_we), .mem_be(mem_be), .mem_opr(mem_opr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    cpu_req = 0; cpu_we = 0; cpu_be = 4'hF; cpu_opr = 3'b010;
    cpu_addr = '0; cpu_wdata = '0;
    host_req = 0; host_lock = 0; host_we = 0; host_be = 4'hF;
    host_addr = '0; host_wdata = '0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h04] = 32'hDEADBEEF;   // byte address 0x0010
    idle_inputs();
    rst = 1'b1;
    #2;
    chk("rst_cpu_gnt",     {31'b0, cpu_gnt},     32'h0);
    chk("rst_host_gnt",    {31'b0, host_gnt},    32'h0);
    chk("rst_cpu_rvalid",  {31'b0, cpu_rvalid},  32'h0);
    chk("rst_host_rvalid", {31'b0, host_rvalid}, 32'h0);
    chk("rst_cpu_rdata",   cpu_rdata,            32'h0);
    chk("rst_host_rdata",  host_rdata,           32'h0);
    chk("rst_mem_we",      {31'b0, mem_we},      32'h0);
    tick(); tick();
    rst = 1'b0;

    // CPU-only read of 0x0010
    cpu_req = 1; cpu_we = 0; cpu_addr = 15'h0010;
    #2;
    chk("cpu_rd_gnt",   {31'b0, cpu_gnt},   32'h1);
    chk("cpu_rd_stall", {31'b0, cpu_stall}, 32'h0);
    chk("cpu_rd_addr",  {17'b0, mem_addr},  32'h0010);
    chk("cpu_rd_we",    {31'b0, mem_we},    32'h0);
    tick();
    cpu_req = 0;
    chk("cpu_rd_rvalid", {31'b0, cpu_rvalid}, 32'h1);
    chk("cpu_rd_rdata",  cpu_rdata,           32'hDEADBEEF);
    tick();
    chk("cpu_rd_rvalid_pulse", {31'b0, cpu_rvalid}, 32'h0);
    chk("cpu_rd_rdata_hold",   cpu_rdata,           32'hDEADBEEF);

    // Contention, both writing; last grant was CPU so host goes first
    cpu_req = 1; cpu_we = 1; cpu_addr = 15'h0020; cpu_wdata = 32'hC0C0C0C0;
    host_req = 1; host_we = 1; host_addr = 15'h0040; host_wdata = 32'hA0A0A0A0;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("cont_host_gnt",  {31'b0, host_gnt},  (i % 2 == 0) ? 32'h1 : 32'h0);
      chk("cont_cpu_gnt",   {31'b0, cpu_gnt},   (i % 2 == 0) ? 32'h0 : 32'h1);
      chk("cont_cpu_stall", {31'b0, cpu_stall}, (i % 2 == 0) ? 32'h1 : 32'h0);
      chk("cont_mem_we",    {31'b0, mem_we},    32'h1);
      chk("cont_mem_addr",  {17'b0, mem_addr},  (i % 2 == 0) ? 32'h0040 : 32'h0020);
      tick();
    end
    idle_inputs();
    chk("wr_no_cpu_rvalid",  {31'b0, cpu_rvalid},  32'h0);
    chk("wr_no_host_rvalid", {31'b0, host_rvalid}, 32'h0);
    tick();
    chk("cont_mem_host", mem[8'h10], 32'hA0A0A0A0);
    chk("cont_mem_cpu",  mem[8'h08], 32'hC0C0C0C0);

    // Host lock: 16 host grants, 1 forced CPU grant, lock resumes with a
    // fresh count (second timeout after another 16)
    cpu_req = 1; cpu_we = 0; cpu_addr = 15'h0020; cpu_opr = 3'b100;
    host_req = 1; host_lock = 1; host_we = 0; host_addr = 15'h0010;
    for (int i = 0; i < 34; i++) begin
      #2;
      chk("lock_host_gnt", {31'b0, host_gnt}, (i == 16 || i == 33) ? 32'h0 : 32'h1);
      chk("lock_cpu_gnt",  {31'b0, cpu_gnt},  (i == 16 || i == 33) ? 32'h1 : 32'h0);
      chk("lock_mem_opr",  {29'b0, mem_opr},  (i == 16 || i == 33) ? 32'h4 : 32'h2);
      tick();
    end
    idle_inputs();
    tick();

    // Lock release after 3 grants; CPU is next, then a new lock gets a full
    // budget of 16
    cpu_req = 1; host_req = 1; host_lock = 1;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("rel_host_gnt", {31'b0, host_gnt}, 32'h1);
      tick();
    end
    host_lock = 0;
    #2;
    chk("rel_cpu_gnt",  {31'b0, cpu_gnt},  32'h1);
    chk("rel_host_off", {31'b0, host_gnt}, 32'h0);
    tick();
    host_lock = 1;
    for (int i = 0; i < 17; i++) begin
      #2;
      chk("relock_host_gnt", {31'b0, host_gnt}, (i == 16) ? 32'h0 : 32'h1);
      tick();
    end
    idle_inputs();
    tick();

    // Host write 0x12345678 to 0x0100, then CPU read of 0x0100
    host_req = 1; host_we = 1; host_addr = 15'h0100; host_wdata = 32'h12345678;
    #2;
    chk("hw_gnt",   {31'b0, host_gnt}, 32'h1);
    chk("hw_we",    {31'b0, mem_we},   32'h1);
    chk("hw_wdata", mem_wdata,         32'h12345678);
    tick();
    idle_inputs();
    chk("hw_no_rvalid", {31'b0, host_rvalid}, 32'h0);
    cpu_req = 1; cpu_addr = 15'h0100;
    #2;
    chk("cr_gnt", {31'b0, cpu_gnt}, 32'h1);
    tick();
    cpu_req = 0;
    chk("cr_rvalid", {31'b0, cpu_rvalid}, 32'h1);
    chk("cr_rdata",  cpu_rdata,           32'h12345678);

    // Host read-back forces word opcode
    host_req = 1; host_addr = 15'h0100;
    #2;
    chk("hr_opr", {29'b0, mem_opr}, 32'h2);
    tick();
    host_req = 0;
    chk("hr_rvalid", {31'b0, host_rvalid}, 32'h1);
    chk("hr_rdata",  host_rdata,           32'h12345678);
    tick();

    // Async reset while a read result is pending
    cpu_req = 1; cpu_addr = 15'h0010;
    tick();
    chk("ar_rvalid_before", {31'b0, cpu_rvalid}, 32'h1);
    chk("ar_rdata_before",  cpu_rdata,           32'hDEADBEEF);
    cpu_req = 1;
    #1;
    rst = 1'b1;
    cpu_req = 0;
    #1;
    chk("ar_rvalid_clear", {31'b0, cpu_rvalid}, 32'h0);
    chk("ar_rdata_clear",  cpu_rdata,           32'h0);
    chk("ar_mem_we",       {31'b0, mem_we},     32'h0);
    tick();
    chk("ar_rvalid_after", {31'b0, cpu_rvalid}, 32'h0);
    rst = 1'b0;
    tick();
    // last_grant is HOST after reset, so contention picks the CPU
    cpu_req = 1; cpu_we = 1; host_req = 1; host_we = 1;
    #2;
    chk("ar_rr_cpu",  {31'b0, cpu_gnt},  32'h1);
    chk("ar_rr_host", {31'b0, host_gnt}, 32'h0);
    tick();
    idle_inputs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
